// File: rtl/flappy_pkg.sv
// Shared constants and types for the Flappy Bird playfield and pipe generator.
package flappy_pkg;

  localparam int ROWS_DEF       = 16;
  localparam int PIPE_WIDTH_DEF = 2;
  localparam int SPACING_DEF    = 4;
  localparam int GAP_H_DEF      = 4;
  localparam int GAP_OFFSET_DEF = 4;

  // Playfield geometry shared with the LED-matrix display driver.
  localparam int PLAYFIELD_ROWS = 16;
  localparam int PLAYFIELD_COLS = 32;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPACE = 2'd1,
    PIPE  = 2'd2
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pipe_gap_mask.sv
// Builds a fully lit pipe column with GAP_H rows cleared starting at gap_base.
module pipe_gap_mask
  import flappy_pkg::*;
#(
  parameter int ROWS  = ROWS_DEF,
  parameter int GAP_H = GAP_H_DEF
) (
  input  logic [CNT_W-1:0] gap_base,
  output logic [ROWS-1:0]  col
);

  logic [CNT_W:0] gap_lo;
  logic [CNT_W:0] gap_hi;

  // One extra bit so gap_base+GAP_H never wraps.
  assign gap_lo = {1'b0, gap_base};
  assign gap_hi = {1'b0, gap_base} + (CNT_W+1)'(GAP_H);

  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      localparam logic [CNT_W:0] ROW_IDX = (CNT_W+1)'(gi);
      assign col[gi] = !((ROW_IDX >= gap_lo) && (ROW_IDX < gap_hi));
    end
  endgenerate

endmodule

// File: rtl/pipe_spawner.sv
// Turns scroll ticks into a stream of spacing/pipe columns with LFSR-placed gaps.
module pipe_spawner
  import flappy_pkg::*;
#(
  parameter int ROWS       = ROWS_DEF,
  parameter int PIPE_WIDTH = PIPE_WIDTH_DEF,
  parameter int SPACING    = SPACING_DEF,
  parameter int GAP_H      = GAP_H_DEF,
  parameter int GAP_OFFSET = GAP_OFFSET_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            active,
  input  logic            shift,
  input  logic [2:0]      rand_in,
  output logic [ROWS-1:0] col_out,
  output logic            col_valid,
  output logic [7:0]      pipe_count
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  space_cnt_q, space_cnt_d;
  logic [CNT_W-1:0]  pipe_cnt_q, pipe_cnt_d;
  logic [CNT_W-1:0]  gap_base_q, gap_base_d;
  logic [ROWS-1:0]   col_out_q, col_out_d;
  logic              col_valid_q, col_valid_d;
  logic [7:0]        pipe_count_q, pipe_count_d;
  logic [ROWS-1:0]   pipe_col;

  pipe_gap_mask #(
    .ROWS  (ROWS),
    .GAP_H (GAP_H)
  ) u_mask (
    .gap_base (gap_base_q),
    .col      (pipe_col)
  );

  always_comb begin
    state_d      = state_q;
    space_cnt_d  = space_cnt_q;
    pipe_cnt_d   = pipe_cnt_q;
    gap_base_d   = gap_base_q;
    col_out_d    = col_out_q;
    col_valid_d  = 1'b0;
    pipe_count_d = pipe_count_q;

    if (!active) begin
      state_d      = IDLE;
      space_cnt_d  = '0;
      pipe_cnt_d   = '0;
      col_out_d    = '0;
      pipe_count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          // shift is deliberately ignored on the cycle the game starts.
          state_d     = SPACE;
          space_cnt_d = '0;
          col_out_d   = '0;
        end
        SPACE: begin
          if (shift) begin
            col_out_d   = '0;
            col_valid_d = 1'b1;
            space_cnt_d = space_cnt_q + 1'b1;
            if (space_cnt_q == CNT_W'(SPACING - 1)) begin
              gap_base_d = {{(CNT_W-3){1'b0}}, rand_in} + CNT_W'(GAP_OFFSET);
              pipe_cnt_d = '0;
              state_d    = PIPE;
            end
          end
        end
        PIPE: begin
          if (shift) begin
            col_out_d   = pipe_col;
            col_valid_d = 1'b1;
            pipe_cnt_d  = pipe_cnt_q + 1'b1;
            if (pipe_cnt_q == CNT_W'(PIPE_WIDTH - 1)) begin
              pipe_count_d = sat_inc8(pipe_count_q);
              space_cnt_d  = '0;
              state_d      = SPACE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      space_cnt_q  <= '0;
      pipe_cnt_q   <= '0;
      gap_base_q   <= '0;
      col_out_q    <= '0;
      col_valid_q  <= 1'b0;
      pipe_count_q <= '0;
    end else begin
      state_q      <= state_d;
      space_cnt_q  <= space_cnt_d;
      pipe_cnt_q   <= pipe_cnt_d;
      gap_base_q   <= gap_base_d;
      col_out_q    <= col_out_d;
      col_valid_q  <= col_valid_d;
      pipe_count_q <= pipe_count_d;
    end
  end

  assign col_out    = col_out_q;
  assign col_valid  = col_valid_q;
  assign pipe_count = pipe_count_q;

endmodule

// File: tb/tb_pipe_spawner.sv
// Directed table-driven bench for pipe_spawner with default parameters.
module tb_pipe_spawner;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        active = 1'b0;
  logic        shift = 1'b0;
  logic [2:0]  rand_in = 3'd0;
  logic [15:0] col_out;
  logic        col_valid;
  logic [7:0]  pipe_count;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_spawner dut (
    .clk        (clk),
    .reset      (reset),
    .active     (active),
    .shift      (shift),
    .rand_in    (rand_in),
    .col_out    (col_out),
    .col_valid  (col_valid),
    .pipe_count (pipe_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        act;
    logic        sh;
    logic [2:0]  rnd;
    logic        exp_valid;
    logic [15:0] exp_col;
    logic [7:0]  exp_count;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic a, logic s, logic [2:0] rn,
                              logic ev, logic [15:0] ec, logic [7:0] en);
    vec_t v;
    v.rst = r; v.act = a; v.sh = s; v.rnd = rn;
    v.exp_valid = ev; v.exp_col = ec; v.exp_count = en;
    return v;
  endfunction

  // Inputs are applied for one cycle; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic r, input logic a, input logic s, input logic [2:0] rn);
    @(negedge clk);
    reset = r; active = a; shift = s; rand_in = rn;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [15:0] act_v, input logic [15:0] exp_v);
    n_checks++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act_v, exp_v);
    end
  endtask

  initial begin
    // 1: reset, then four empty spacing columns
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 16'h0000, 0));  // shift ignored as active rises
    vecs.push_back(mk(0, 1, 1, 0, 1, 16'h0000, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 1, 1, 3, 1, 16'h0000, 0));
    vecs.push_back(mk(0, 1, 1, 3, 1, 16'h0000, 0));
    vecs.push_back(mk(0, 1, 1, 3, 1, 16'h0000, 0));
    // 2: pipe with rand 3 -> rows 7..10 clear
    vecs.push_back(mk(0, 1, 1, 3, 1, 16'hF87F, 0));
    vecs.push_back(mk(0, 1, 0, 3, 0, 16'hF87F, 0));  // holds between strobes
    vecs.push_back(mk(0, 1, 1, 0, 1, 16'hF87F, 1));
    // 3a: rand 0, then rand changes during the pipe
    vecs.push_back(mk(0, 1, 1, 0, 1, 16'h0000, 1));
    vecs.push_back(mk(0, 1, 1, 0, 1, 16'h0000, 1));
    vecs.push_back(mk(0, 1, 1, 0, 1, 16'h0000, 1));
    vecs.push_back(mk(0, 1, 1, 0, 1, 16'h0000, 1));
    vecs.push_back(mk(0, 1, 1, 5, 1, 16'hFF0F, 1));
    vecs.push_back(mk(0, 1, 1, 6, 1, 16'hFF0F, 2));
    // 3b: rand 7 lockup value
    vecs.push_back(mk(0, 1, 1, 7, 1, 16'h0000, 2));
    vecs.push_back(mk(0, 1, 1, 7, 1, 16'h0000, 2));
    vecs.push_back(mk(0, 1, 1, 7, 1, 16'h0000, 2));
    vecs.push_back(mk(0, 1, 1, 7, 1, 16'h0000, 2));
    vecs.push_back(mk(0, 1, 1, 1, 1, 16'h87FF, 2));
    vecs.push_back(mk(0, 1, 1, 1, 1, 16'h87FF, 3));
    // 4: drop active mid-pipe (rand 1 -> rows 5..8 clear)
    vecs.push_back(mk(0, 1, 1, 1, 1, 16'h0000, 3));
    vecs.push_back(mk(0, 1, 1, 1, 1, 16'h0000, 3));
    vecs.push_back(mk(0, 1, 1, 1, 1, 16'h0000, 3));
    vecs.push_back(mk(0, 1, 1, 1, 1, 16'h0000, 3));
    vecs.push_back(mk(0, 1, 1, 2, 1, 16'hFE1F, 3));
    vecs.push_back(mk(0, 0, 1, 2, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 1, 1, 2, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 1, 1, 2, 1, 16'h0000, 0));
    // 5: six back-to-back shifts (rand 2 -> rows 6..9 clear), then reset with shift
    vecs.push_back(mk(0, 1, 1, 2, 1, 16'h0000, 0));
    vecs.push_back(mk(0, 1, 1, 2, 1, 16'h0000, 0));
    vecs.push_back(mk(0, 1, 1, 2, 1, 16'h0000, 0));
    vecs.push_back(mk(0, 1, 1, 2, 1, 16'hFC3F, 0));
    vecs.push_back(mk(0, 1, 1, 2, 1, 16'hFC3F, 1));
    vecs.push_back(mk(0, 1, 1, 2, 1, 16'h0000, 1));
    vecs.push_back(mk(1, 1, 1, 2, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].act, vecs[i].sh, vecs[i].rnd);
      check("col_valid", i, {15'd0, col_valid}, {15'd0, vecs[i].exp_valid});
      check("col_out", i, col_out, vecs[i].exp_col);
      check("pipe_count", i, {8'd0, pipe_count}, {8'd0, vecs[i].exp_count});
      $display("vec %0d: rst=%0b act=%0b sh=%0b rnd=%0d -> valid=%0b col=%h cnt=%0d",
               i, vecs[i].rst, vecs[i].act, vecs[i].sh, vecs[i].rnd, col_valid, col_out, pipe_count);
    end

    // 6: run 257 complete pipes and check saturation of pipe_count
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    for (int p = 1; p <= 257; p++) begin
      for (int s = 0; s < 6; s++) begin
        step(0, 1, 1, 3'(p));
        check("sat_valid", p, {15'd0, col_valid}, 16'd1);
      end
      check("sat_count", p, {8'd0, pipe_count}, (p > 255) ? 16'd255 : 16'(p));
      if (p >= 254)
        $display("pipe %0d: pipe_count=%0d", p, pipe_count);
    end
    step(0, 1, 0, 0);
    check("sat_idle_valid", 0, {15'd0, col_valid}, 16'd0);
    check("sat_hold", 0, {8'd0, pipe_count}, 16'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
